// File: rtl/branch_cond_eval.sv
// branch_cond_eval: evaluates a 4-bit branch condition code against a stored
// NZCV-style flag nibble, one request at a time, with valid/ready handshakes.
//
// Flow: IDLE accepts a request (flags, cond, tag), EVAL computes the result
// into the output register, RESP presents it until the consumer takes it.
// Accept at edge N -> resp_valid seen at edge N+2 -> earliest next accept N+3.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flags[3:0]      {z, n, c, v}
//   cond[3:0]       condition code (bit 3 inverts the sense of codes 0-7)
//   tag_in          request identifier, echoed on tag_out
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   resp_valid/resp_ready  response handshake (valid only in RESP)
//   taken           condition result, stable while resp_valid
//   tag_out         tag of the request being answered
//   taken_count     delivered taken results (saturating)
//
// Optional feature: define BRANCH_COUNT_EN to build the taken_count counter;
// without it taken_count is tied to zero.
module branch_cond_eval #(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       flags,
    input  logic [3:0]       cond,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             taken,
    output logic [TAG_W-1:0] tag_out,
    output logic [15:0]      taken_count
);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       flags_q;
    logic [3:0]       cond_q;
    logic [TAG_W-1:0] tag_q;
    logic             accept;
    logic             handshake;
    logic             base_hit;
    logic             cond_hit;

    assign accept    = req_valid && req_ready;
    assign handshake = resp_valid && resp_ready;

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = EVAL;
            end
            EVAL: state_d = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Inputs are sampled only on accept; later changes are invisible.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
            cond_q  <= '0;
            tag_q   <= '0;
        end else if (accept) begin
            flags_q <= flags;
            cond_q  <= cond;
            tag_q   <= tag_in;
        end
    end

    // Codes 8-F are the complements of codes 0-7, so decode the low three
    // bits and let bit 3 flip the result.
    always_comb begin
        base_hit = 1'b0;
        case (cond_q[2:0])
            3'd0: base_hit = 1'b0;
            3'd1: base_hit = flags_q[3];
            3'd2: base_hit = flags_q[3] | (flags_q[2] ^ flags_q[0]);
            3'd3: base_hit = flags_q[2] ^ flags_q[0];
            3'd4: base_hit = flags_q[1] | flags_q[3];
            3'd5: base_hit = flags_q[1];
            3'd6: base_hit = flags_q[2];
            3'd7: base_hit = flags_q[0];
            default: base_hit = 1'b0;
        endcase
    end

    assign cond_hit = base_hit ^ cond_q[3];

    // Result registers load only in EVAL, so they hold through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken   <= 1'b0;
            tag_out <= '0;
        end else if (state_q == EVAL) begin
            taken   <= cond_hit;
            tag_out <= tag_q;
        end
    end

`ifdef BRANCH_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            taken_count <= '0;
        else if (handshake && taken && (taken_count != 16'hFFFF))
            taken_count <= taken_count + 16'd1;
    end
`else
    assign taken_count = '0;
`endif

endmodule

// File: tb/tb_branch_cond_eval.sv
module tb_branch_cond_eval;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] flags, cond;
    logic [7:0] tag_in;
    logic       req_valid, req_ready, resp_valid, resp_ready, taken;
    logic [7:0] tag_out;
    logic [15:0] taken_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    branch_cond_eval #(.TAG_W(8)) dut (
        .clk(clk), .rst(rst), .flags(flags), .cond(cond), .tag_in(tag_in),
        .req_valid(req_valid), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .taken(taken), .tag_out(tag_out), .taken_count(taken_count)
    );

    typedef struct {
        logic [3:0] f;
        logic [3:0] c;
        logic [7:0] t;
        int         stall;
        logic       exp_taken;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: condition table spelled out code by code from named flags.
    function automatic logic model_taken(input logic [3:0] f, input logic [3:0] c);
        bit z, n, cy, v;
        z = f[3]; n = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return 1'b0;
            4'h1: return z;
            4'h2: return z || (n != v);
            4'h3: return n != v;
            4'h4: return cy || z;
            4'h5: return cy;
            4'h6: return n;
            4'h7: return v;
            4'h8: return 1'b1;
            4'h9: return !z;
            4'hA: return !(z || (n != v));
            4'hB: return n == v;
            4'hC: return !(cy || z);
            4'hD: return !cy;
            4'hE: return !n;
            default: return !v;
        endcase
    endfunction

    function automatic int expected_count();
`ifdef BRANCH_COUNT_EN
        return exp_count;
`else
        return 0;
`endif
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic txn(input logic [3:0] f, input logic [3:0] c, input logic [7:0] t,
                       input int stall, input logic exp_t, input string nm);
        chk({nm, " req_ready idle"}, req_ready, 1);
        flags = f; cond = c; tag_in = t; req_valid = 1'b1;
        resp_ready = 1'($urandom);
        @(posedge clk);                       // accept edge N
        @(negedge clk);
        flags = 4'($urandom); cond = 4'($urandom); tag_in = 8'($urandom);
        req_valid = 1'($urandom); resp_ready = 1'($urandom);
        chk({nm, " resp_valid eval"}, resp_valid, 0);
        chk({nm, " req_ready eval"}, req_ready, 0);
        @(posedge clk);                       // N+1
        @(negedge clk);
        chk({nm, " resp_valid"}, resp_valid, 1);
        chk({nm, " taken"}, taken, exp_t);
        chk({nm, " tag_out"}, tag_out, t);
        for (int i = 0; i < stall; i++) begin
            resp_ready = 1'b0;
            req_valid = 1'b1; flags = 4'($urandom); cond = 4'($urandom); tag_in = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk({nm, " stall resp_valid"}, resp_valid, 1);
            chk({nm, " stall taken"}, taken, exp_t);
            chk({nm, " stall tag_out"}, tag_out, t);
            chk({nm, " stall req_ready"}, req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);                       // handshake edge
        if (exp_t && exp_count < 16'hFFFF) exp_count++;
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b0;
        chk({nm, " resp_valid done"}, resp_valid, 0);
        chk({nm, " req_ready done"}, req_ready, 1);
        chk({nm, " taken_count"}, taken_count, expected_count());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{f: 4'b1000, c: 4'h1, t: 8'h5A, stall: 0, exp_taken: 1'b1}; // eq, first-cycle handshake
        vecs[1] = '{f: 4'b0100, c: 4'hB, t: 8'h11, stall: 0, exp_taken: 1'b0}; // ge with n=1 v=0
        vecs[2] = '{f: 4'b0100, c: 4'h3, t: 8'h22, stall: 1, exp_taken: 1'b1}; // lt
        vecs[3] = '{f: 4'b0000, c: 4'h0, t: 8'hFF, stall: 2, exp_taken: 1'b0}; // never
        vecs[4] = '{f: 4'b0000, c: 4'h8, t: 8'h00, stall: 0, exp_taken: 1'b1}; // always
        vecs[5] = '{f: 4'b0010, c: 4'hC, t: 8'h33, stall: 0, exp_taken: 1'b0}; // hi, c=1
        vecs[6] = '{f: 4'b0101, c: 4'hA, t: 8'h44, stall: 0, exp_taken: 1'b1}; // gt, n=v z=0
        vecs[7] = '{f: 4'b0001, c: 4'hF, t: 8'h77, stall: 10, exp_taken: 1'b0}; // vc, long stall

        rst = 1'b1; req_valid = 1'b1; resp_ready = 1'b1;
        flags = '0; cond = '0; tag_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        chk("reset req_ready", req_ready, 1);
        chk("reset resp_valid", resp_valid, 0);
        chk("reset taken", taken, 0);
        chk("reset tag_out", tag_out, 0);
        chk("reset taken_count", taken_count, 0);

        foreach (vecs[i])
            txn(vecs[i].f, vecs[i].c, vecs[i].t, vecs[i].stall, vecs[i].exp_taken, $sformatf("vec%0d", i));

        // Every condition code against every flag value.
        for (int c = 0; c < 16; c++)
            for (int f = 0; f < 16; f++)
                txn(4'(f), 4'(c), 8'(c * 16 + f), 0, model_taken(4'(f), 4'(c)), "sweep");

        // Reset in EVAL kills the request.
        do_reset();
        flags = 4'b1000; cond = 4'h1; tag_in = 8'hC3; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_eval resp_valid", resp_valid, 0);
        chk("rst_eval req_ready", req_ready, 1);
        chk("rst_eval tag_out", tag_out, 0);
        begin
            int seen = 0;
            repeat (6) begin
                @(posedge clk);
                @(negedge clk);
                if (resp_valid) seen++;
            end
            chk("rst_eval no response", seen, 0);
        end
        resp_ready = 1'b0;
        exp_count = 0;

        // Reset in RESP with resp_ready high: reset wins.
        flags = 4'b0000; cond = 4'h8; tag_in = 8'h9E; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_resp pre resp_valid", resp_valid, 1);
        rst = 1'b1; resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; resp_ready = 1'b0;
        chk("rst_resp resp_valid", resp_valid, 0);
        chk("rst_resp taken", taken, 0);
        chk("rst_resp taken_count", taken_count, 0);

        // Random traffic, counter: 3 taken + 2 not-taken runs after reset too.
        do_reset();
        txn(4'b1000, 4'h1, 8'h01, 0, 1'b1, "cnt_t1");
        txn(4'b1000, 4'h9, 8'h02, 1, 1'b0, "cnt_n1");
        txn(4'b0000, 4'h8, 8'h03, 0, 1'b1, "cnt_t2");
        txn(4'b0000, 4'h0, 8'h04, 0, 1'b0, "cnt_n2");
        txn(4'b0010, 4'h5, 8'h05, 2, 1'b1, "cnt_t3");
        chk("count after 3 taken", taken_count, expected_count());
        for (int i = 0; i < 150; i++) begin
            logic [3:0] rf, rc;
            rf = 4'($urandom); rc = 4'($urandom);
            txn(rf, rc, 8'($urandom), int'($urandom_range(0, 3)), model_taken(rf, rc), "rand");
        end

`ifdef BRANCH_COUNT_EN
        // Saturation: preload the counter near its ceiling.
        @(negedge clk);
        dut.taken_count = 16'hFFFF;
        exp_count = 16'hFFFF;
        txn(4'b0000, 4'h8, 8'hAA, 0, 1'b1, "sat");
        chk("saturated count", taken_count, 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
